// File: rtl/pcie_fifo_pkg.sv
// rtl/pcie_fifo_pkg.sv - shared constants and sizing helpers for the PCIe TLP FIFO
// Used by pcie_fifo_mem and pcie_sync_fifo (PCIE_FIFO_FWFT_EN selects the top's read mode).
package pcie_fifo_pkg;

    localparam int DEFAULT_DATA_WIDTH = 12;
    localparam int DEFAULT_DEPTH      = 8;

    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive, hence one bit more than the pointers.
    function automatic int occ_width(input int depth);
        return clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/pcie_fifo_mem.sv
// rtl/pcie_fifo_mem.sv - DEPTH x DATA_WIDTH simple dual-port RAM, sync write, async read
// Storage is never reset; the top's pointers define which entries are live.
module pcie_fifo_mem
    import pcie_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pcie_sync_fifo.sv
// rtl/pcie_sync_fifo.sv - single-clock FIFO with registered flags and sticky overflow/underflow
// Define PCIE_FIFO_FWFT_EN for first-word-fall-through; otherwise data_out is registered on pop.
module pcie_sync_fifo
    import pcie_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int ADDR_WIDTH = clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE    = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   FULL_LEVEL = (ADDR_WIDTH + 1)'(DEPTH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   count_next;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  push_ok;
    logic                  pop_ok;

    // A pop frees a slot in the same edge, so a push at full is accepted alongside it.
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);

    always_comb begin
        count_next = count;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count + CNT_ONE;
            2'b01:   count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    pcie_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push_ok & ~reset),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            count        <= count_next;
            full         <= (count_next == FULL_LEVEL);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= af_thresh);
            almost_empty <= (count_next <= ae_thresh);
            if (push & full & ~pop_ok) begin
                overflow <= 1'b1;
            end
            if (pop & empty) begin
                underflow <= 1'b1;
            end
        end
    end

`ifdef PCIE_FIFO_FWFT_EN
    // Head entry shown directly; forced to zero while empty so stale RAM never leaks out.
    assign data_out = empty ? '0 : rd_data;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            data_out <= '0;
        end else if (pop_ok) begin
            data_out <= rd_data;
        end
    end
`endif

endmodule

// File: tb/tb_pcie_sync_fifo.sv
// tb/tb_pcie_sync_fifo.sv - directed and randomized self-checking bench for pcie_sync_fifo
// Expected values come from a queue-based model; PCIE_FIFO_FWFT_EN selects the read-mode model.
module tb_pcie_sync_fifo;

    localparam int DW    = 12;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic          clk;
    logic          reset;
    logic          push;
    logic [DW-1:0] data_in;
    logic          pop;
    logic [DW-1:0] data_out;
    logic [AW:0]   af_thresh;
    logic [AW:0]   ae_thresh;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic          almost_empty;
    logic          overflow;
    logic          underflow;

    int n_checks = 0;
    int n_errors = 0;

    int            m_q[$];
    bit            m_af;
    bit            m_ae;
    bit            m_ovf;
    bit            m_unf;
    logic [DW-1:0] m_dout;

    pcie_sync_fifo dut (
        .clk          (clk),
        .reset        (reset),
        .push         (push),
        .data_in      (data_in),
        .pop          (pop),
        .data_out     (data_out),
        .af_thresh    (af_thresh),
        .ae_thresh    (ae_thresh),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] expected_dout();
`ifdef PCIE_FIFO_FWFT_EN
        return (m_q.size() > 0) ? DW'(m_q[0]) : '0;
`else
        return m_dout;
`endif
    endfunction

    task automatic check_all(input string tag);
        check({tag, ".count"},        32'(count),        32'(m_q.size()));
        check({tag, ".full"},         32'(full),         32'(m_q.size() == DEPTH));
        check({tag, ".empty"},        32'(empty),        32'(m_q.size() == 0));
        check({tag, ".almost_full"},  32'(almost_full),  32'(m_af));
        check({tag, ".almost_empty"}, 32'(almost_empty), 32'(m_ae));
        check({tag, ".overflow"},     32'(overflow),     32'(m_ovf));
        check({tag, ".underflow"},    32'(underflow),    32'(m_unf));
        check({tag, ".data_out"},     32'(data_out),     32'(expected_dout()));
    endtask

    // One clock: drive, take the edge, advance the model, compare every output.
    task automatic cycle(input string tag, input bit rst, input bit p, input logic [DW-1:0] d, input bit o);
        bit pop_ok;
        bit push_ok;
        int head;
        reset   = rst;
        push    = p;
        data_in = d;
        pop     = o;
        @(posedge clk);
        #1;
        if (rst) begin
            m_q.delete();
            m_af   = 1'b0;
            m_ae   = 1'b1;
            m_ovf  = 1'b0;
            m_unf  = 1'b0;
            m_dout = '0;
        end else begin
            pop_ok  = o && (m_q.size() > 0);
            push_ok = p && ((m_q.size() < DEPTH) || pop_ok);
            if (p && !push_ok) m_ovf = 1'b1;
            if (o && m_q.size() == 0) m_unf = 1'b1;
            if (pop_ok) begin
                head   = m_q.pop_front();
                m_dout = DW'(head);
            end
            if (push_ok) m_q.push_back(int'(d));
            m_af = (m_q.size() >= int'(af_thresh));
            m_ae = (m_q.size() <= int'(ae_thresh));
        end
        check_all(tag);
    endtask

    initial begin
        reset     = 1'b1;
        push      = 1'b0;
        pop       = 1'b0;
        data_in   = '0;
        af_thresh = 4'd6;
        ae_thresh = 4'd1;

        cycle("reset0", 1, 0, 0, 0);
        cycle("reset1", 1, 1, 12'h3FF, 1);
        check("reset_empty", 32'(empty), 32'd1);
        check("reset_data_out", 32'(data_out), 32'd0);

        cycle("underflow", 0, 0, 0, 1);
        check("underflow_flag", 32'(underflow), 32'd1);
        check("underflow_count", 32'(count), 32'd0);
        for (int i = 0; i < 3; i++) cycle("underflow_hold", 0, 0, 0, 0);

        cycle("rst_fill", 1, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) cycle("fill", 0, 1, DW'(i), 0);
        check("fill_full", 32'(full), 32'd1);
        cycle("overflow", 0, 1, 12'h0AA, 0);
        check("overflow_flag", 32'(overflow), 32'd1);
        check("overflow_count", 32'(count), 32'd8);
        for (int i = 1; i <= DEPTH; i++) cycle("drain", 0, 0, 0, 1);
        check("drain_empty", 32'(empty), 32'd1);
        cycle("drain_extra", 0, 0, 0, 1);

        cycle("rst_conc", 1, 0, 0, 0);
        for (int i = 1; i <= DEPTH; i++) cycle("fill2", 0, 1, DW'(12'h100 + i), 0);
        cycle("conc_full", 0, 1, 12'h123, 1);
        check("conc_full_overflow", 32'(overflow), 32'd0);
        for (int i = 1; i <= DEPTH; i++) cycle("drain2", 0, 0, 0, 1);
`ifndef PCIE_FIFO_FWFT_EN
        check("wrap_last", 32'(data_out), 32'h123);
`endif

        cycle("rst_conc_empty", 1, 0, 0, 0);
        cycle("conc_empty", 0, 1, 12'h055, 1);
        check("conc_empty_count", 32'(count), 32'd1);
        check("conc_empty_underflow", 32'(underflow), 32'd1);
        cycle("conc_empty_pop", 0, 0, 0, 1);

        cycle("rst_mid", 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) cycle("mid_fill", 0, 1, DW'(12'h200 + i), 0);
        for (int i = 0; i < 3; i++) cycle("mid_pop", 0, 0, 0, 1);
        check("mid_count", 32'(count), 32'd5);
        cycle("mid_reset", 1, 0, 0, 0);
        check("mid_reset_count", 32'(count), 32'd0);
        cycle("mid_after", 0, 0, 0, 0);

        af_thresh = 4'd0;
        cycle("af0_reset", 1, 0, 0, 0);
        check("af0_in_reset", 32'(almost_full), 32'd0);
        cycle("af0_exit", 0, 0, 0, 0);
        check("af0_after", 32'(almost_full), 32'd1);
        af_thresh = 4'd8;
        ae_thresh = 4'd0;
        cycle("thresh_edges", 0, 1, 12'h777, 0);

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0) begin
                af_thresh = 4'($urandom_range(0, DEPTH));
                ae_thresh = 4'($urandom_range(0, DEPTH));
            end
            cycle("random", ($urandom_range(0, 99) == 0),
                  ($urandom_range(0, 99) < 55), DW'($urandom), ($urandom_range(0, 99) < 45));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
